// File: rtl/videoram_pkg.sv
// Shared videoram definitions: coordinate widths, default visible geometry,
// {row,col} address pack/unpack helpers and the fill engine state encoding.
package videoram_pkg;
    localparam int ROW_W    = 16;
    localparam int COL_W    = 16;
    localparam int ADDR_W   = ROW_W + COL_W;
    localparam int ROWS_DEF = 350;
    localparam int COLS_DEF = 720;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } fill_state_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

    function automatic logic [ROW_W-1:0] unpack_row(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:COL_W];
    endfunction

    function automatic logic [COL_W-1:0] unpack_col(input logic [ADDR_W-1:0] addr);
        return addr[COL_W-1:0];
    endfunction
endpackage

// File: rtl/raster_counter.sv
// 2-D raster offset counter, column-fastest. r_nxt/c_nxt expose the offsets
// that the next step will load so callers can register the following pixel.
module raster_counter
    import videoram_pkg::*;
#(
    parameter int RW = ROW_W,
    parameter int CW = COL_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          step,
    input  logic [CW-1:0] width,
    input  logic [RW-1:0] height,
    output logic [RW-1:0] r_off,
    output logic [CW-1:0] c_off,
    output logic [RW-1:0] r_nxt,
    output logic [CW-1:0] c_nxt,
    output logic          last
);
    logic row_end;

    always_comb begin
        row_end = (c_off == width - CW'(1));
        c_nxt   = row_end ? '0 : c_off + CW'(1);
        r_nxt   = row_end ? r_off + RW'(1) : r_off;
        last    = row_end && (r_off == height - RW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_off <= '0;
            c_off <= '0;
        end else if (step) begin
            r_off <= r_nxt;
            c_off <= c_nxt;
        end
    end
endmodule

// File: rtl/videoram_filler.sv
// Rectangle fill engine: one registered single-bit videoram write per clock.
// Define VIDEORAM_FILL_CLIP_EN to suppress writes outside ROWS x COLS.
module videoram_filler
    import videoram_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ROW_W-1:0]  cmd_row,
    input  logic [COL_W-1:0]  cmd_col,
    input  logic [ROW_W-1:0]  cmd_height,
    input  logic [COL_W-1:0]  cmd_width,
    input  logic              cmd_color,
    input  logic              cmd_checker,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              wdata,
    output logic              busy,
    output logic              done
);
    fill_state_t       state, state_nxt;
    logic [ROW_W-1:0]  row_q, h_q, r_off, r_nxt;
    logic [COL_W-1:0]  col_q, w_q, c_off, c_nxt;
    logic              color_q, chk_q, last;
    logic              accept, step, emit, pix_ok;
    logic [ROW_W:0]    row_sum;
    logic [COL_W:0]    col_sum;
    logic              color_s, chk_s;
    logic              we_p0, done_p0, wdata_p0;
    logic [ADDR_W-1:0] waddr_p0;

    raster_counter #(.RW(ROW_W), .CW(COL_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .step   (step),
        .width  (w_q),
        .height (h_q),
        .r_off  (r_off),
        .c_off  (c_off),
        .r_nxt  (r_nxt),
        .c_nxt  (c_nxt),
        .last   (last)
    );

`ifdef VIDEORAM_FILL_CLIP_EN
    // Un-wrapped sums, so coordinates past 65535 are treated as off-screen.
    assign pix_ok = (row_sum < (ROW_W+1)'(ROWS)) && (col_sum < (COL_W+1)'(COLS));
`else
    logic unused_cfg;
    assign pix_ok     = 1'b1;
    assign unused_cfg = (ROWS != COLS) ^ row_sum[ROW_W] ^ col_sum[COL_W];
`endif

    // Stage p0: pixel that will be presented after the coming edge.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        emit      = 1'b0;
        we_p0     = 1'b0;
        done_p0   = 1'b0;
        row_sum   = {1'b0, row_q} + {1'b0, r_nxt};
        col_sum   = {1'b0, col_q} + {1'b0, c_nxt};
        color_s   = color_q;
        chk_s     = chk_q;
        case (state)
            S_IDLE: begin
                row_sum = {1'b0, cmd_row};
                col_sum = {1'b0, cmd_col};
                color_s = cmd_color;
                chk_s   = cmd_checker;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_width == '0 || cmd_height == '0) begin
                        done_p0 = 1'b1;
                    end else begin
                        state_nxt = S_FILL;
                        emit      = 1'b1;
                        we_p0     = pix_ok;
                    end
                end
            end
            S_FILL: begin
                if (last) begin
                    state_nxt = S_IDLE;
                    done_p0   = 1'b1;
                end else begin
                    step  = 1'b1;
                    emit  = 1'b1;
                    we_p0 = pix_ok;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign waddr_p0  = pack_addr(row_sum[ROW_W-1:0], col_sum[COL_W-1:0]);
    assign wdata_p0  = color_s ^ (chk_s & (row_sum[0] ^ col_sum[0]));
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_FILL);

    // Stage p0 -> registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            we    <= we_p0;
            done  <= done_p0;
            if (emit) begin
                waddr <= waddr_p0;
                wdata <= wdata_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            row_q   <= cmd_row;
            col_q   <= cmd_col;
            h_q     <= cmd_height;
            w_q     <= cmd_width;
            color_q <= cmd_color;
            chk_q   <= cmd_checker;
        end
    end
endmodule

// File: tb/tb_videoram_filler.sv
// Self-checking bench for videoram_filler against a raster-loop reference model.
module tb_videoram_filler;
    localparam int ROWS = 350;
    localparam int COLS = 720;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_row = '0, cmd_col = '0, cmd_height = '0, cmd_width = '0;
    logic        cmd_color = 1'b0, cmd_checker = 1'b0;
    logic        we, wdata, busy, done;
    logic [31:0] waddr;

    int n_cmp = 0;
    int n_fail = 0;

    bit          exp_we[$];
    logic [31:0] exp_addr[$];
    bit          exp_data[$];

    always #5 clk = ~clk;

    videoram_filler dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_height(cmd_height),
        .cmd_width(cmd_width), .cmd_color(cmd_color), .cmd_checker(cmd_checker),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
    );

    // Expected per-cycle writes for one command, straight from the raster rules.
    task automatic build(input int row, input int col, input int h, input int w,
                         input bit color, input bit chk);
        exp_we.delete(); exp_addr.delete(); exp_data.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int rr, cc;
                logic [15:0] ar, ac;
                rr = row + r;
                cc = col + c;
                ar = rr[15:0];
                ac = cc[15:0];
                exp_addr.push_back({ar, ac});
                exp_data.push_back(color ^ (chk & (ar[0] ^ ac[0])));
`ifdef VIDEORAM_FILL_CLIP_EN
                exp_we.push_back((rr < ROWS) && (cc < COLS));
`else
                exp_we.push_back(1'b1);
`endif
            end
        end
    endtask

    // Drives one handshake; returns just after the accepting edge.
    task automatic issue(input logic [15:0] row, input logic [15:0] col,
                         input logic [15:0] h, input logic [15:0] w,
                         input logic color, input logic chk);
        cmd_row = row; cmd_col = col; cmd_height = h; cmd_width = w;
        cmd_color = color; cmd_checker = chk; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_row = 16'($urandom); cmd_col = 16'($urandom);
        cmd_height = 16'($urandom); cmd_width = 16'($urandom);
        cmd_color = 1'($urandom); cmd_checker = 1'($urandom);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (we !== 1'b0 || waddr !== 32'h0 || wdata !== 1'b0 || done !== 1'b0 ||
            busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: we=%b waddr=%h wdata=%b done=%b busy=%b ready=%b, want 0 0 0 0 0 1",
                     we, waddr, wdata, done, busy, cmd_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || we !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: ready=%b we=%b done=%b, want 1 0 0", cmd_ready, we, done);
        end
    endtask

    task automatic test_solid;
        build(2, 5, 2, 3, 1'b1, 1'b0);
        issue(16'd2, 16'd5, 16'd2, 16'd3, 1'b1, 1'b0);
        for (int i = 0; i < exp_addr.size(); i++) begin
            @(negedge clk);
            n_cmp++;
            if (we !== exp_we[i] || waddr !== exp_addr[i] || wdata !== exp_data[i] ||
                busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL solid[%0d]: we=%b waddr=%h wdata=%b busy=%b done=%b, want %b %h %b 1 0",
                         i, we, waddr, wdata, busy, done, exp_we[i], exp_addr[i], exp_data[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || we !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL solid_done: done=%b we=%b ready=%b, want 1 0 1", done, we, cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL solid_done_pulse: done=%b, want 0", done);
        end
    endtask

    task automatic test_checker;
        build(0, 0, 2, 2, 1'b0, 1'b1);
        issue(16'd0, 16'd0, 16'd2, 16'd2, 1'b0, 1'b1);
        for (int i = 0; i < exp_addr.size(); i++) begin
            @(negedge clk);
            n_cmp++;
            if (we !== exp_we[i] || waddr !== exp_addr[i] || wdata !== exp_data[i]) begin
                n_fail++;
                $display("FAIL checker[%0d]: we=%b waddr=%h wdata=%b, want %b %h %b",
                         i, we, waddr, wdata, exp_we[i], exp_addr[i], exp_data[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL checker_done: done=%b, want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_size;
        logic [15:0] hs[2] = '{16'd4, 16'd0};
        logic [15:0] ws[2] = '{16'd0, 16'd7};
        for (int k = 0; k < 2; k++) begin
            issue(16'd10, 16'd10, hs[k], ws[k], 1'b1, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b1 || we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_size[%0d]: done=%b we=%b busy=%b ready=%b, want 1 0 0 1",
                         k, done, we, busy, cmd_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || we !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_size_after[%0d]: done=%b we=%b, want 0 0", k, done, we);
            end
        end
    endtask

    task automatic test_back_to_back;
        issue(16'd7, 16'd9, 16'd1, 16'd1, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (we !== 1'b1 || waddr !== 32'h0007_0009 || wdata !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: we=%b waddr=%h wdata=%b, want 1 00070009 1", we, waddr, wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_ready: done=%b ready=%b, want 1 1", done, cmd_ready);
        end
        issue(16'd1, 16'd2, 16'd1, 16'd1, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (we !== 1'b1 || waddr !== 32'h0001_0002 || wdata !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: we=%b waddr=%h wdata=%b done=%b, want 1 00010002 0 0",
                     we, waddr, wdata, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_done: done=%b, want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            logic [15:0] row, col, h, w;
            logic color, chk;
            case ($urandom_range(0, 3))
                0: begin row = 16'($urandom); col = 16'($urandom); end
                1: begin row = 16'($urandom_range(65532, 65535)); col = 16'($urandom_range(65532, 65535)); end
                2: begin row = 16'($urandom_range(346, 352)); col = 16'($urandom_range(716, 722)); end
                default: begin row = 16'($urandom_range(0, 20)); col = 16'($urandom_range(0, 20)); end
            endcase
            h = 16'($urandom_range(0, 4));
            w = 16'($urandom_range(0, 5));
            color = 1'($urandom);
            chk = 1'($urandom);
            build(int'(row), int'(col), int'(h), int'(w), color, chk);
            n_cmp++;
            if (cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: ready=%b, want 1", n, cmd_ready);
            end
            issue(row, col, h, w, color, chk);
            for (int i = 0; i < exp_addr.size(); i++) begin
                @(negedge clk);
                n_cmp++;
                if (we !== exp_we[i] || waddr !== exp_addr[i] || wdata !== exp_data[i] ||
                    busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand[%0d][%0d]: we=%b waddr=%h wdata=%b busy=%b ready=%b done=%b, want %b %h %b 1 0 0",
                             n, i, we, waddr, wdata, busy, cmd_ready, done,
                             exp_we[i], exp_addr[i], exp_data[i]);
                end
                // Offers during a fill must be ignored.
                cmd_valid = 1'($urandom);
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            n_cmp++;
            if (done !== 1'b1 || we !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_done[%0d]: done=%b we=%b busy=%b, want 1 0 0", n, done, we, busy);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                n_cmp++;
                if (done !== 1'b0 || we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_gap[%0d]: done=%b we=%b, want 0 0", n, done, we);
                end
            end
        end
        @(negedge clk);
    endtask

`ifdef VIDEORAM_FILL_CLIP_EN
    task automatic test_clip;
        bit want_we[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        build(349, 718, 2, 3, 1'b1, 1'b0);
        issue(16'd349, 16'd718, 16'd2, 16'd3, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (we !== want_we[i] || waddr !== exp_addr[i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL clip[%0d]: we=%b waddr=%h busy=%b, want %b %h 1",
                         i, we, waddr, busy, want_we[i], exp_addr[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL clip_done: done=%b, want 1", done);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_midfill;
        int bad;
        issue(16'd3, 16'd3, 16'd4, 16'd4, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (we !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midfill_running: we=%b busy=%b, want 1 1", we, busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (we !== 1'b0 || waddr !== 32'h0 || wdata !== 1'b0 || done !== 1'b0 ||
            busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midfill_reset: we=%b waddr=%h wdata=%b done=%b busy=%b ready=%b, want 0 0 0 0 0 1",
                     we, waddr, wdata, done, busy, cmd_ready);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0 || we !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midfill_abandon: %0d cycles with done/we/ready wrong, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_checker();
        test_zero_size();
        test_back_to_back();
`ifdef VIDEORAM_FILL_CLIP_EN
        test_clip();
`endif
        test_random();
        test_reset_midfill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
